mb32_acc_stage: RTL and testbench
=================================

# mb32_acc_stage

Downstream consumer of the mb32_top radix-4 Booth multiplier. Accepts the 2·WIDTH-bit product stream beat by beat and accumulates it into a guarded running sum. On a last-marked beat it closes the burst and presents the sum, beat count and overflow flag through a one-entry valid/ready output register. Used for dot-product and MAC reduction behind the multiplier pipeline.

## Interface
- WIDTH, 32, multiplier operand width; the product is 2·WIDTH bits.
- GUARD, 8, guard bits; accumulator width ACC_W = 2·WIDTH+GUARD.
- CNT_W, 16, beat-counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- prod_in  in  2·WIDTH  unsigned product from the multiplier.
- prod_valid  in  1  prod_in is valid this cycle.
- prod_last  in  1  final beat of the burst; qualified by prod_valid.
- in_ready  out  1  stage can accept a beat this cycle.
- acc_out  out  ACC_W  burst sum.
- acc_cnt  out  CNT_W  number of beats in the burst.
- acc_ovf  out  1  the burst overflowed ACC_W.
- out_valid  out  1  acc_out, acc_cnt and acc_ovf are valid.
- out_ready  in  1  consumer takes the result this cycle.

## Operation
- Accept: acc = prod_valid & in_ready. No beat is taken when acc=0; prod_last is ignored unless prod_valid=1.
- Internal state: running sum s (ACC_W), count c (CNT_W), sticky flag v.
- Sum: s_next = s + zero-extended prod_in, computed at ACC_W+1 bits. A carry out of ACC_W sets v.
  - s_next takes the value of the overflow rule in Configuration.
  - c increments and saturates at all-ones.
- Accepted beat with prod_last=0: s, c and v take their next values.
- Accepted beat with prod_last=1:
  - The output register loads the burst: acc_out←s_next, acc_cnt←c+1 (saturating), acc_ovf←v_next.
  - out_valid←1.
  - s, c and v clear to 0 for the next burst.
- Output register state machine:
  - EMPTY (out_valid=0) → FULL on an accepted last beat.
  - FULL → EMPTY on out_ready=1 with no accepted last beat in the same cycle.
  - FULL → FULL (reload) on out_ready=1 with an accepted last beat in the same cycle; the new result replaces the old one with no bubble.
  - FULL with out_ready=0: all outputs held stable.
- in_ready = !RST & (!out_valid | out_ready). This is combinational. While in_ready=0, every beat (last or not) is stalled.
- The upstream controller must not issue multiplier operands whose products would arrive while in_ready=0. mb32_top has no stall path.

## Timing
- Reset: after an RST cycle, s=0, c=0, v=0, out_valid=0, acc_out=0, acc_cnt=0, acc_ovf=0. in_ready=0 while RST=1 and 1 on the first cycle after.
- Reset mid-burst discards the partial sum and any pending output. No result is produced for the aborted burst.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N. Consumer pop to new accept is 0 cycles.
- Throughput: one beat per cycle while out_ready=1 or the output register is empty.
- Single-beat burst (prod_valid=prod_last=1 on one beat) is legal and yields cnt=1.

## Configuration
- ACC_SAT_EN defined: on carry out, s_next clamps to 2^ACC_W−1. Once clamped, the sum stays there for the rest of the burst. v=1.
- ACC_SAT_EN undefined: s_next wraps modulo 2^ACC_W; v is still set and sticky.
- Either way, acc_ovf reports the overflow.

## Test plan
Defaults WIDTH=32, GUARD=8 (ACC_W=72).
- Single beat: prod_in=0x0000_0001_0000_0000, valid=last=1, out_ready=1 → next cycle out_valid=1, acc_out=0x1_0000_0000, acc_cnt=1, acc_ovf=0. out_valid falls one cycle later.
- Burst: 4 back-to-back beats of 0xFFFF_FFFE_0000_0001, last on the 4th → acc_out=0x3_FFFF_FFF8_0000_0004, acc_cnt=4, acc_ovf=0.
- Backpressure sequence:
  - Result pending, out_ready=0 → in_ready=0, outputs stable over 5 cycles, and a held valid last beat of 7 is not taken.
  - Raise out_ready → same cycle pop + accept; next cycle out_valid=1, acc_out=7, acc_cnt=1.
- Overflow: 257 beats of 0xFFFF_FFFF_FFFF_FFFF, last on the 257th → acc_cnt=257, acc_ovf=1.
  - Without ACC_SAT_EN: acc_out=0xFFFF_FFFF_FFFF_FEFF.
  - With ACC_SAT_EN: acc_out=0xFF_FFFF_FFFF_FFFF_FFFF. After 256 beats alone (last on the 256th), acc_ovf=0.
- Reset mid-burst: 2 non-last beats of 9, then RST=1 for one cycle → in_ready=0 during RST, no out_valid. Then a single last beat of 5 → acc_out=5, acc_cnt=1.

Source files
------------

// File: rtl/mb32_acc_stage.sv
// Burst accumulator behind the Booth multiplier: result valid one edge after the last beat,
// one-entry output register stalls input while full and unread; ACC_SAT_EN selects clamp-on-overflow instead of wrap.
module mb32_acc_stage #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2*WIDTH-1:0]         prod_in,
  input  logic                       prod_valid,
  input  logic                       prod_last,
  output logic                       in_ready,
  output logic [2*WIDTH+GUARD-1:0]   acc_out,
  output logic [CNT_W-1:0]           acc_cnt,
  output logic                       acc_ovf,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int ACC_W  = 2*WIDTH + GUARD;
  localparam int PROD_W = 2*WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  out_state_e       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic             v_q, v_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic             beat_acc;
  logic             last_acc;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic [ACC_W-1:0] s_next;
  logic [CNT_W-1:0] c_next;
  logic             v_next;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !RST && (!out_valid || out_ready);
  assign beat_acc  = prod_valid && in_ready;
  assign last_acc  = beat_acc && prod_last;

  assign acc_out = acc_out_q;
  assign acc_cnt = acc_cnt_q;
  assign acc_ovf = acc_ovf_q;

  always_comb begin
    sum_wide = {1'b0, s_q} + {{(ACC_W+1-PROD_W){1'b0}}, prod_in};
    carry    = sum_wide[ACC_W];
`ifdef ACC_SAT_EN
    // A clamped sum keeps carrying on any nonzero beat, so it stays pinned.
    s_next   = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    s_next   = sum_wide[ACC_W-1:0];
`endif
    v_next   = v_q | carry;
    c_next   = (c_q == {CNT_W{1'b1}}) ? c_q : c_q + 1'b1;
  end

  always_comb begin
    s_d       = s_q;
    c_d       = c_q;
    v_d       = v_q;
    acc_out_d = acc_out_q;
    acc_cnt_d = acc_cnt_q;
    acc_ovf_d = acc_ovf_q;
    state_d   = state_q;

    if (beat_acc) begin
      if (prod_last) begin
        acc_out_d = s_next;
        acc_cnt_d = c_next;
        acc_ovf_d = v_next;
        s_d       = '0;
        c_d       = '0;
        v_d       = 1'b0;
      end else begin
        s_d = s_next;
        c_d = c_next;
        v_d = v_next;
      end
    end

    unique case (state_q)
      ST_EMPTY: if (last_acc) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !last_acc) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_EMPTY;
      s_q       <= '0;
      c_q       <= '0;
      v_q       <= 1'b0;
      acc_out_q <= '0;
      acc_cnt_q <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      v_q       <= v_d;
      acc_out_q <= acc_out_d;
      acc_cnt_q <= acc_cnt_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_mb32_acc_stage.sv
// Directed self-checking bench for mb32_acc_stage (expectations follow ACC_SAT_EN).
module tb_mb32_acc_stage;

  localparam int WIDTH = 32;
  localparam int GUARD = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 2*WIDTH + GUARD;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [2*WIDTH-1:0]   prod_in;
  logic                 prod_valid;
  logic                 prod_last;
  logic                 in_ready;
  logic [ACC_W-1:0]     acc_out;
  logic [CNT_W-1:0]     acc_cnt;
  logic                 acc_ovf;
  logic                 out_valid;
  logic                 out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  mb32_acc_stage #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_last (prod_last),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .acc_cnt   (acc_cnt),
    .acc_ovf   (acc_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; prod_in = '0; prod_valid = 1'b0; prod_last = 1'b0; out_ready = 1'b1;
    step(); step();
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    RST = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || acc_out !== '0 || acc_cnt !== '0 || acc_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: vld=%b out=%h cnt=%0d ovf=%b want 0/0/0/0", out_valid, acc_out, acc_cnt, acc_ovf);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_beat();
    prod_in = 64'h0000_0001_0000_0000; prod_valid = 1'b1; prod_last = 1'b1; out_ready = 1'b1;
    step();
    prod_valid = 1'b0; prod_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || acc_out !== 72'h1_0000_0000 || acc_cnt !== 16'd1 || acc_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_beat: vld=%b out=%h cnt=%0d ovf=%b want 1/100000000/1/0", out_valid, acc_out, acc_cnt, acc_ovf);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_beat_drop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_burst();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod_in = 64'hFFFF_FFFE_0000_0001; prod_valid = 1'b1; prod_last = (i == 3);
      step();
      if (i < 3) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++; $display("FAIL burst_early_valid: beat %0d out_valid=%b want 0", i, out_valid);
        end
      end
    end
    prod_valid = 1'b0; prod_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || acc_out !== 72'h3_FFFF_FFF8_0000_0004 || acc_cnt !== 16'd4 || acc_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst4: vld=%b out=%h cnt=%0d ovf=%b want 1/3fffffff800000004/4/0", out_valid, acc_out, acc_cnt, acc_ovf);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    prod_in = 64'd3; prod_valid = 1'b1; prod_last = 1'b1;
    step();
    prod_in = 64'd7;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 72'd3 || acc_cnt !== 16'd1 || acc_ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold: cyc %0d rdy=%b vld=%b out=%h cnt=%0d want 0/1/3/1", i, in_ready, out_valid, acc_out, acc_cnt);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL backpressure_release_rdy: got %b want 1", in_ready);
    end
    step();
    prod_valid = 1'b0; prod_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || acc_out !== 72'd7 || acc_cnt !== 16'd1 || acc_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_reload: vld=%b out=%h cnt=%0d ovf=%b want 1/7/1/0", out_valid, acc_out, acc_cnt, acc_ovf);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure_pop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_overflow(input int nbeats, input logic [ACC_W-1:0] exp_out, input logic exp_ovf);
    out_ready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      prod_in = 64'hFFFF_FFFF_FFFF_FFFF; prod_valid = 1'b1; prod_last = (i == nbeats - 1);
      step();
    end
    prod_valid = 1'b0; prod_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || acc_out !== exp_out || acc_cnt !== nbeats[CNT_W-1:0] || acc_ovf !== exp_ovf) begin
      tests_failed++;
      $display("FAIL overflow_%0d: vld=%b out=%h cnt=%0d ovf=%b want 1/%h/%0d/%b",
               nbeats, out_valid, acc_out, acc_cnt, acc_ovf, exp_out, nbeats, exp_ovf);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prod_in = 64'd9; prod_valid = 1'b1; prod_last = 1'b0;
      step();
    end
    prod_valid = 1'b0;
    RST = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_rdy: got %b want 0", in_ready);
    end
    step();
    RST = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset_after: vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    prod_in = 64'd5; prod_valid = 1'b1; prod_last = 1'b1;
    step();
    prod_valid = 1'b0; prod_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || acc_out !== 72'd5 || acc_cnt !== 16'd1 || acc_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_fresh: vld=%b out=%h cnt=%0d ovf=%b want 1/5/1/0", out_valid, acc_out, acc_cnt, acc_ovf);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_burst();
    test_backpressure();
`ifdef ACC_SAT_EN
    test_overflow(257, 72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
`else
    test_overflow(257, 72'h00_FFFF_FFFF_FFFF_FEFF, 1'b1);
`endif
    test_overflow(256, 72'hFF_FFFF_FFFF_FFFF_FF00, 1'b0);
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
